toggle_handshake_rx: RTL and testbench
======================================

Name: toggle_handshake_rx

Overview:
- Receiving end of the two-phase (toggle) handshake.
- The sender drives `req_tgl` from a T flip-flop and flips it once per word.
- This block synchronizes `req_tgl`, turns each level change into one captured word on a valid/ready output, and returns a toggling `ack_tgl` to the sender once the word is consumed.
- It sits at a clock-domain or module boundary, in front of any consumer that uses valid/ready.

Parameters:
- DATA_W, 8, width of the transferred word.
- SYNC_STAGES, 2, number of synchronizer flops on `req_tgl` (minimum 2).
- CNT_W, 8, width of the accepted-transfer counter.

Ports:
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on the `clk` rising edge).
- req_tgl  in  1  request toggle from the sender; asynchronous to `clk`.
- req_data  in  DATA_W  sender data; stable from the `req_tgl` flip until `ack_tgl` flips.
- ack_tgl  out  1  acknowledge toggle; flips once per consumed word.
- out_valid  out  1  a captured word is held on `out_data`.
- out_data  out  DATA_W  the captured word.
- out_ready  in  1  consumer accepts the word when high together with `out_valid`.
- evt_count  out  CNT_W  number of words consumed; wraps modulo 2^CNT_W.
- overrun  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (`reset` = 0 at a clk edge):
  - Cleared to 0: sync chain, previous-sample flop, `ack_tgl`, `out_valid`, `out_data`, `evt_count`, `overrun`.
  - FSM goes to IDLE.
  - The sender's T flip-flop is also reset to 0, so both toggles start equal.
- Synchronizer and edge detect:
  - `req_tgl` passes through SYNC_STAGES flops, then one more flop (`prev`).
  - `req_evt` = sync output XOR `prev`; it is a one-cycle pulse per `req_tgl` level change.
- FSM states: IDLE, HOLD.
- IDLE:
  - On `req_evt`: capture `req_data` into `out_data`, set `out_valid` = 1, go to HOLD.
  - No other outputs change.
- HOLD:
  - On `out_valid && out_ready` at a clk edge, all in the same edge:
    - clear `out_valid`;
    - flip `ack_tgl`;
    - increment `evt_count` (wrapping);
    - return to IDLE.
  - `out_data` keeps its value after the handshake until the next capture.
- Latency:
  - `req_tgl` flip to `out_valid` high = SYNC_STAGES+1 clk edges (3 with defaults).
  - If `out_ready` is already high, `ack_tgl` flips on the next edge after `out_valid` rises.
  - Minimum spacing between accepted words: SYNC_STAGES+2 cycles.
- Overrun:
  - A `req_evt` while in HOLD, and not on the edge where the handshake completes, is a sender protocol violation.
  - Response: set `overrun` = 1 (sticky until reset), discard the new word, keep the held word, do not flip `ack_tgl`, do not count.
- Simultaneous `req_evt` and handshake completion in HOLD:
  - The handshake completes normally and the FSM returns to IDLE.
  - The event is lost.
  - `overrun` is set.
- `out_ready` high while in IDLE: no effect.
- Reset mid-operation (in HOLD with `out_valid` = 1): the held word is dropped, no ack is issued, and all outputs return to reset values on that edge.
- `evt_count` at 2^CNT_W−1 plus one accepted transfer: wraps to 0, `overrun` unaffected.

Decomposition:
- Shared package `toggle_hs_pkg`:
  - FSM state typedef (IDLE = 0, HOLD = 1);
  - default constants DATA_W_DEF = 8 and SYNC_STAGES_DEF = 2.
- One sub-module `toggle_sync`: SYNC_STAGES synchronizer plus `prev` flop plus XOR, producing `req_evt`.
  - Parameterized by SYNC_STAGES.
  - Uses the same clk and reset.
  - The sender side can reuse it for `ack_tgl`.

Test Plan:
- Reset: hold `reset` = 0 for 3 cycles with `req_tgl` toggling → `ack_tgl`=0, `out_valid`=0, `evt_count`=0, `overrun`=0 throughout.
- Single transfer: `req_data`=8'hA5, flip `req_tgl` 0→1, `out_ready`=1 → `out_valid` high 3 edges later with `out_data`=8'hA5; `ack_tgl`=1 one edge after; `evt_count`=1.
- Backpressure: `out_ready`=0, send 8'h3C → `out_valid` stays 1 and `out_data`=8'h3C for 10 cycles, `ack_tgl` unchanged; raise `out_ready` → `ack_tgl` flips on the next edge, `evt_count` increments.
- Overrun: while held on 8'h11 with `out_ready`=0, flip `req_tgl` again with 8'h22 → `overrun`=1, `out_data` stays 8'h11, one ack only after release, `evt_count` +1 only.
- Wrap: CNT_W=4, perform 17 well-formed transfers (1..17) → `evt_count`=1 at end, `ack_tgl`=1 (odd count), `overrun`=0.
- Mid-operation reset: assert `reset`=0 while HOLD on 8'hFF → next edge `out_valid`=0, `ack_tgl`=0, `evt_count`=0; the first transfer after release works as in the single-transfer case.

Source files
------------

// File: rtl/toggle_hs_pkg.sv
// Shared types and defaults for the toggle-handshake receiver.
// Holds the FSM state encoding and the default widths/depths.
package toggle_hs_pkg;

    // Receiver FSM: IDLE waits for a request toggle, HOLD presents
    // the captured word until the consumer takes it.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/toggle_handshake_rx_if.sv
// Bundle of the two-phase request side and the valid/ready output side.
// master: sender + consumer view, slave: receiver (toggle_handshake_rx).
interface toggle_handshake_rx_if
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              req_tgl;
    logic [DATA_W-1:0] req_data;
    logic              ack_tgl;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output req_tgl,
        output req_data,
        output out_ready,
        input  ack_tgl,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  req_tgl,
        input  req_data,
        input  out_ready,
        output ack_tgl,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/toggle_sync.sv
// Synchronizer plus edge detector for a toggle signal.
// Ports: clk, reset (sync, active-low), tgl_i (async toggle),
//        evt_o (one-cycle pulse per level change of tgl_i).
module toggle_sync
    import toggle_hs_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF  // must be >= 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tgl_i,
    output logic evt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // Bit 0 is the metastability-catching flop; the MSB is the
    // first value safe to use in logic.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tgl_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign evt_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receiving end of a two-phase (toggle) handshake with valid/ready output.
// Ports: clk, reset (sync, active-low), bus (slave: req_tgl/req_data in,
//        ack_tgl out, out_valid/out_data/out_ready), evt_count, overrun.
module toggle_handshake_rx
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    toggle_handshake_rx_if.slave bus,
    output logic [CNT_W-1:0]     evt_count,
    output logic                 overrun
);

    state_t            state_q;
    state_t            state_d;
    logic              valid_q;
    logic              valid_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              ack_q;
    logic              ack_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              ovr_q;
    logic              ovr_d;
    logic              req_evt;
    logic              hs_done;

    toggle_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .tgl_i (bus.req_tgl),
        .evt_o (req_evt)
    );

    assign hs_done = valid_q & bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_evt) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hs_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (req_evt) begin
                    valid_d = 1'b1;
                    data_d  = bus.req_data;
                end
            end
            HOLD: begin
                if (hs_done) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                // A new toggle while a word is still held cannot be
                // stored; it is dropped even if the handshake completes
                // on this same edge.
                if (req_evt) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.ack_tgl   = ack_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign evt_count     = cnt_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx.
// Two DUTs (8-bit and 4-bit counters) share one stimulus stream.
module tb_toggle_handshake_rx;
    import toggle_hs_pkg::*;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r_req;
    logic       r_rdy;
    logic [7:0] r_data;
    logic [7:0] cnt8;
    logic [3:0] cnt4;
    logic       ovr8;
    logic       ovr4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    toggle_handshake_rx_if #(.DATA_W(8)) bus ();
    toggle_handshake_rx_if #(.DATA_W(8)) bus4 ();

    assign bus.req_tgl    = r_req;
    assign bus.req_data   = r_data;
    assign bus.out_ready  = r_rdy;
    assign bus4.req_tgl   = r_req;
    assign bus4.req_data  = r_data;
    assign bus4.out_ready = r_rdy;

    toggle_handshake_rx #(
        .DATA_W(8), .SYNC_STAGES(S), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(rst_n), .bus(bus),
        .evt_count(cnt8), .overrun(ovr8)
    );

    toggle_handshake_rx #(
        .DATA_W(8), .SYNC_STAGES(S), .CNT_W(4)
    ) dut4 (
        .clk(clk), .reset(rst_n), .bus(bus4),
        .evt_count(cnt4), .overrun(ovr4)
    );

    // Reference model: transaction-level state plus a history of the
    // sampled request level; a flip becomes visible S+1 edges later.
    bit         m_held;
    logic [7:0] m_word;
    bit         m_ack;
    bit         m_ovr;
    int         m_cnt;
    bit         rh[$];

    function automatic void model_clear();
        m_held = 0;
        m_word = 8'h00;
        m_ack  = 0;
        m_ovr  = 0;
        m_cnt  = 0;
        rh.delete();
        repeat (S + 1) rh.push_front(1'b0);
    endfunction

    function automatic void model_edge();
        bit evt;
        if (!rst_n) begin
            model_clear();
        end else begin
            evt = rh[S-1] ^ rh[S];
            if (!m_held) begin
                if (evt) begin
                    m_held = 1;
                    m_word = r_data;
                end
            end else begin
                if (r_rdy) begin
                    m_held = 0;
                    m_ack  = ~m_ack;
                    m_cnt++;
                end
                if (evt) m_ovr = 1;
            end
            rh.push_front(r_req);
            while (rh.size() > S + 1) void'(rh.pop_back());
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("valid",   32'(bus.out_valid),  32'(m_held));
        chk("data",    32'(bus.out_data),   32'(m_word));
        chk("ack",     32'(bus.ack_tgl),    32'(m_ack));
        chk("count",   32'(cnt8),           m_cnt & 255);
        chk("overrun", 32'(ovr8),           32'(m_ovr));
        chk("valid4",  32'(bus4.out_valid), 32'(m_held));
        chk("ack4",    32'(bus4.ack_tgl),   32'(m_ack));
        chk("count4",  32'(cnt4),           m_cnt & 15);
        chk("ovr4",    32'(ovr4),           32'(m_ovr));
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_valid_timeout"}, 32'(bus.out_valid), 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        r_req = 1'b0;
        r_rdy = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] d);
        int n = 0;
        r_data = d;
        r_req  = ~r_req;
        r_rdy  = 1'b1;
        while (bus.ack_tgl !== r_req && n < 20) begin
            step();
            n++;
        end
        chk("send_ack", 32'(bus.ack_tgl), 32'(r_req));
        step();
    endtask

    typedef struct {
        bit         rst;
        bit         req;
        logic [7:0] d;
        bit         rdy;
        bit         v;
        logic [7:0] od;
        bit         ack;
        logic [7:0] cnt;
        bit         ovr;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int lat;

        // rst req data rdy | valid data ack cnt ovr
        tbl[0] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 8'd0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd1, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 8'd1, 1'b0};

        model_clear();
        rst_n  = 1'b0;
        r_req  = 1'b0;
        r_rdy  = 1'b0;
        r_data = 8'h00;

        // Reset with toggling request, then a single transfer.
        for (int i = 0; i < 9; i++) begin
            rst_n  = tbl[i].rst;
            r_req  = tbl[i].req;
            r_data = tbl[i].d;
            r_rdy  = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].v));
            chk($sformatf("vec%0d_data", i),  32'(bus.out_data),  32'(tbl[i].od));
            chk($sformatf("vec%0d_ack", i),   32'(bus.ack_tgl),   32'(tbl[i].ack));
            chk($sformatf("vec%0d_cnt", i),   32'(cnt8),          32'(tbl[i].cnt));
            chk($sformatf("vec%0d_ovr", i),   32'(ovr8),          32'(tbl[i].ovr));
        end

        // Backpressure: word held for 10 cycles, released later.
        r_rdy  = 1'b0;
        r_data = 8'h3C;
        r_req  = ~r_req;
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_valid", 32'(bus.out_valid), 1);
            chk("bp_hold_data",  32'(bus.out_data),  32'h3C);
            chk("bp_hold_ack",   32'(bus.ack_tgl),   1);
        end
        r_rdy = 1'b1;
        step();
        chk("bp_ack",   32'(bus.ack_tgl), 0);
        chk("bp_cnt",   32'(cnt8),        2);
        chk("bp_valid", 32'(bus.out_valid), 0);

        // New toggle lands on the same edge as the handshake.
        r_rdy  = 1'b0;
        r_data = 8'h44;
        r_req  = ~r_req;
        wait_valid("sim");
        r_data = 8'h55;
        r_req  = ~r_req;
        step();
        step();
        r_rdy = 1'b1;
        step();
        chk("sim_valid", 32'(bus.out_valid), 0);
        chk("sim_ack",   32'(bus.ack_tgl),   1);
        chk("sim_cnt",   32'(cnt8),          3);
        chk("sim_ovr",   32'(ovr8),          1);
        chk("sim_data",  32'(bus.out_data),  32'h44);
        repeat (4) step();
        chk("sim_lost", 32'(bus.out_valid), 0);

        // Overrun while a word is held.
        apply_reset();
        r_data = 8'h11;
        r_req  = ~r_req;
        wait_valid("ovr");
        r_data = 8'h22;
        r_req  = ~r_req;
        repeat (5) step();
        chk("ovr_flag", 32'(ovr8),         1);
        chk("ovr_data", 32'(bus.out_data), 32'h11);
        chk("ovr_ack",  32'(bus.ack_tgl),  0);
        r_rdy = 1'b1;
        step();
        chk("ovr_rel_ack", 32'(bus.ack_tgl), 1);
        repeat (5) step();
        chk("ovr_one_ack", 32'(bus.ack_tgl),   1);
        chk("ovr_cnt",     32'(cnt8),          1);
        chk("ovr_idle",    32'(bus.out_valid), 0);

        // Reset while holding a word, then a clean transfer.
        r_rdy  = 1'b0;
        r_data = 8'hFF;
        r_req  = ~r_req;
        wait_valid("mid");
        chk("mid_held", 32'(bus.out_data), 32'hFF);
        rst_n = 1'b0;
        r_req = 1'b0;
        step();
        chk("mid_valid", 32'(bus.out_valid), 0);
        chk("mid_ack",   32'(bus.ack_tgl),   0);
        chk("mid_cnt",   32'(cnt8),          0);
        chk("mid_ovr",   32'(ovr8),          0);
        rst_n  = 1'b1;
        r_data = 8'hA5;
        r_req  = 1'b1;
        r_rdy  = 1'b1;
        lat    = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("post_latency", 32'(lat),          3);
        chk("post_data",    32'(bus.out_data), 32'hA5);
        step();
        chk("post_ack", 32'(bus.ack_tgl), 1);
        chk("post_cnt", 32'(cnt8),        1);

        // Counter wrap on the 4-bit instance.
        apply_reset();
        for (int i = 1; i <= 17; i++) send_ok(8'(i));
        chk("wrap_cnt4", 32'(cnt4),        1);
        chk("wrap_cnt8", 32'(cnt8),        17);
        chk("wrap_ack",  32'(bus.ack_tgl), 1);
        chk("wrap_ovr",  32'(ovr4),        0);

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            r_rdy = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                r_req = 1'b0;
            end else begin
                rst_n = 1'b1;
                if (bus.ack_tgl == r_req && $urandom_range(0, 3) == 0) begin
                    r_req  = ~r_req;
                    r_data = 8'($urandom);
                end else if ($urandom_range(0, 99) == 0) begin
                    r_req  = ~r_req;
                    r_data = 8'($urandom);
                end
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
